// File: rtl/gf2m_reduce_pent.sv
// Reduces a 2M-bit carry-less product modulo x^M + x^K3 + x^K2 + x^K1 + 1 using two
// register folds. Optional sticky illegal-input flag under `GF_REDUCE_CHK_EN.
module gf2m_reduce_pent #(
    parameter int M  = 571,
    parameter int K3 = 10,
    parameter int K2 = 5,
    parameter int K1 = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*M-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M-1:0]   out_data
`ifdef GF_REDUCE_CHK_EN
    ,
    output logic           err
`endif
);

    localparam int W = M + K3;

    typedef enum logic [1:0] {IDLE, FOLD1, FOLD2, DONE} state_e;

    state_e         state_q, state_d;
    logic [2*M-1:0] r_q, r_d;
    logic           in_ready_q;
    logic [W-1:0]   h_w;
    logic [W-1:0]   fold_w;
    logic [2*M-1:0] folded_w;
    logic           accept_w;

    // The fold is M+K3 wide so the x^K3 term's overflow lands in r[M+K3-1:M] for the next fold.
    assign h_w      = W'(r_q[2*M-1:M]);
    assign fold_w   = W'(r_q[M-1:0]) ^ h_w ^ (h_w << K1) ^ (h_w << K2) ^ (h_w << K3);
    assign folded_w = (2*M)'(fold_w);
    assign accept_w = in_valid && in_ready_q;

    // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        unique case (state_q)
            IDLE: begin
                if (accept_w) begin
                    r_d     = in_data;
                    state_d = FOLD1;
                end
            end
            FOLD1: begin
                r_d     = folded_w;
                state_d = FOLD2;
            end
            FOLD2: begin
                r_d     = folded_w;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            r_q        <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            in_ready_q <= (state_d == IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == DONE);
    assign out_data  = r_q[M-1:0];

`ifdef GF_REDUCE_CHK_EN
    // A true M x M product never reaches degree 2M-1; flag it once and keep it until reset.
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_q | (accept_w && in_data[2*M-1]);
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_gf2m_reduce_pent.sv
// Self-checking bench for gf2m_reduce_pent: fixed vectors, random vectors against a
// long-division reference, backpressure, mid-operation reset and (optionally) the err flag.
module tb_gf2m_reduce_pent;

    localparam int M  = 571;
    localparam int K3 = 10;
    localparam int K2 = 5;
    localparam int K1 = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*M-1:0] in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [M-1:0]   out_data;
`ifdef GF_REDUCE_CHK_EN
    logic           err;
`endif

    int checks = 0;
    int errors = 0;

    gf2m_reduce_pent #(.M(M), .K3(K3), .K2(K2), .K1(K1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef GF_REDUCE_CHK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*M-1:0] din;
        logic [M-1:0]   exp;
        string          name;
    } vec_t;

    // Schoolbook polynomial remainder: cancel each set bit above degree M-1 with a shifted f(x).
    function automatic logic [M-1:0] ref_mod(input logic [2*M-1:0] a);
        logic [2*M-1:0] x;
        logic [2*M-1:0] f;
        x = a;
        f = '0;
        f[M] = 1'b1; f[K3] = 1'b1; f[K2] = 1'b1; f[K1] = 1'b1; f[0] = 1'b1;
        for (int i = 2*M-1; i >= M; i--)
            if (x[i]) x = x ^ (f << (i - M));
        return x[M-1:0];
    endfunction

    function automatic logic [2*M-1:0] rand_wide();
        logic [2*M-1:0] v;
        v = '0;
        for (int i = 0; i < (2*M + 31) / 32; i++)
            v = (v << 32) | (2*M)'($urandom);
        return v;
    endfunction

    task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits (bounded) for in_ready, performs one handshake and returns at the negedge in FOLD1.
    task automatic launch(input logic [2*M-1:0] din, input string name);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " in_ready"}, M'(in_ready), M'(1));
        in_valid = 1'b1;
        in_data  = din;
        @(negedge clk);
        in_valid = 1'b0;
        check({name, " fold1 out_valid"}, M'(out_valid), M'(0));
    endtask

    task automatic reduce(input logic [2*M-1:0] din, input logic [M-1:0] exp, input string name);
        launch(din, name);
        @(negedge clk);
        check({name, " fold2 out_valid"}, M'(out_valid), M'(0));
        @(negedge clk);
        check({name, " T+3 out_valid"}, M'(out_valid), M'(1));
        check({name, " out_data"}, out_data, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " T+4 in_ready"}, M'(in_ready), M'(1));
        check({name, " T+4 out_valid"}, M'(out_valid), M'(0));
    endtask

    vec_t           vecs[4];
    logic [2*M-1:0] a, b;
    logic [M-1:0]   held;

    initial begin
        vecs[0].din = '0; vecs[0].din[571]  = 1'b1;
        vecs[0].exp = M'(12'h425);                       vecs[0].name = "x^571";
        vecs[1].din = '0; vecs[1].din[1140] = 1'b1;
        vecs[1].exp = '0;
        vecs[1].exp[569] = 1'b1; vecs[1].exp[18] = 1'b1; vecs[1].exp[3] = 1'b1;
        vecs[1].exp[2]   = 1'b1; vecs[1].exp[0]  = 1'b1; vecs[1].name = "x^1140";
        vecs[2].din = (2*M)'(16'h1234);
        vecs[2].exp = M'(16'h1234);                      vecs[2].name = "low_degree";
        vecs[3].din = '0;
        vecs[3].exp = '0;                                vecs[3].name = "zero";

        // Reset state
        #12;
        check("reset in_ready",  M'(in_ready),  M'(0));
        check("reset out_valid", M'(out_valid), M'(0));
        check("reset out_data",  out_data,      '0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) reduce(vecs[i].din, vecs[i].exp, vecs[i].name);

        for (int i = 0; i < 8; i++) begin
            a = rand_wide();
            reduce(a, ref_mod(a), $sformatf("rand%0d", i));
        end

        // Backpressure: result held, new data ignored, then the next product goes through.
        a = rand_wide();
        b = rand_wide();
        launch(a, "bp");
        repeat (2) @(negedge clk);
        held = out_data;
        check("bp out_data", held, ref_mod(a));
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp hold out_valid", M'(out_valid), M'(1));
            check("bp hold out_data",  out_data,      ref_mod(a));
            check("bp hold in_ready",  M'(in_ready),  M'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp release in_ready", M'(in_ready), M'(1));
        reduce(b, ref_mod(b), "bp next");

        // Reset during FOLD2 discards the in-flight result.
        a = rand_wide();
        launch(a, "rst_mid");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid out_valid", M'(out_valid), M'(0));
        check("rst_mid out_data",  out_data,      '0);
        check("rst_mid in_ready",  M'(in_ready),  M'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_mid no result", M'(out_valid), M'(0));
        end
        b = rand_wide();
        reduce(b, ref_mod(b), "rst_mid next");

`ifdef GF_REDUCE_CHK_EN
        rst = 1'b0;
        #1;
        check("err reset", M'(err), M'(0));
        @(negedge clk);
        rst = 1'b1;
        a = rand_wide();
        a[2*M-1] = 1'b0;
        reduce(a, ref_mod(a), "err clean");
        check("err clean stays 0", M'(err), M'(0));
        a[2*M-1] = 1'b1;
        launch(a, "err bad");
        check("err set T+1", M'(err), M'(1));
        repeat (2) @(negedge clk);
        check("err bad out_data", out_data, ref_mod(a));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        a[2*M-1] = 1'b0;
        reduce(a, ref_mod(a), "err after");
        check("err sticky", M'(err), M'(1));
        rst = 1'b0;
        #1;
        check("err cleared", M'(err), M'(0));
        @(negedge clk);
        rst = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
